// File: rtl/mario_pkg.sv
// Shared encodings for the mario_motion player-motion engine: FSM states,
// sprite frame codes and key-vector bit positions.
package mario_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STAND  = 3'd1,
    ST_RUN    = 3'd2,
    ST_AIR    = 3'd3,
    ST_CROUCH = 3'd4,
    ST_OVER   = 3'd5
  } state_e;

  localparam logic [3:0] ANIM_STAND  = 4'd0;
  localparam logic [3:0] ANIM_AIR    = 4'd8;
  localparam logic [3:0] ANIM_CROUCH = 4'd9;
  localparam logic [3:0] ANIM_OVER   = 4'd10;
  localparam logic [3:0] ANIM_DJUMP  = 4'd11;

  localparam int KEY_RIGHT = 4;
  localparam int KEY_LEFT  = 3;
  localparam int KEY_JUMP  = 2;
  localparam int KEY_UP    = 1;
  localparam int KEY_DOWN  = 0;

endpackage

// File: rtl/mario_axis_integrator.sv
// One motion axis: unsigned fixed-point position plus signed speed, saturated
// to [0, MAX_INT] px with the fraction cleared at either bound.
module mario_axis_integrator #(
  parameter int INT_W   = 10,
  parameter int FRAC_W  = 4,
  parameter int SPD_W   = 8,
  parameter int MAX_INT = 624
) (
  input  logic [INT_W+FRAC_W-1:0] pos_i,
  input  logic signed [SPD_W-1:0] speed_i,
  output logic [INT_W+FRAC_W-1:0] pos_o,
  output logic                    at_lo_o,
  output logic                    at_hi_o
);

  localparam int POS_W = INT_W + FRAC_W;
  localparam int SUM_W = POS_W + 1;
  localparam logic signed [SUM_W-1:0] HI_LIM = SUM_W'(MAX_INT * (2 ** FRAC_W));

  logic signed [SUM_W-1:0] sum;

  // The extra sign bit lets both bounds be tested before truncation.
  always_comb begin
    sum     = $signed({1'b0, pos_i}) + SUM_W'(speed_i);
    at_lo_o = sum[SUM_W-1] || (sum == '0);
    at_hi_o = !at_lo_o && (sum >= HI_LIM);
    if (at_lo_o)      pos_o = '0;
    else if (at_hi_o) pos_o = HI_LIM[POS_W-1:0];
    else              pos_o = sum[POS_W-1:0];
  end

endmodule

// File: rtl/mario_motion.sv
// Player-motion engine: walk/jump/crouch/gravity integrated once per tick.
// Define MARIO_DOUBLE_JUMP_EN to allow one extra jump while airborne.
module mario_motion
  import mario_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int FRAC_W   = 4,
  parameter int SPD_W    = 8,
  parameter int X_START  = 16,
  parameter int X_MAX    = 624,
  parameter int Y_GROUND = 400,
  parameter int WALK_V   = 32,
  parameter int JUMP_V   = 96,
  parameter int GRAVITY  = 6,
  parameter int MAX_FALL = 120,
  parameter int ANIM_DIV = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    start,
  input  logic                    over,
  input  logic [4:0]              keydown,
  output logic [X_W-1:0]          x,
  output logic [Y_W-1:0]          y,
  output logic [2:0]              state,
  output logic [3:0]              animation_state,
  output logic signed [SPD_W-1:0] xspeed,
  output logic signed [SPD_W-1:0] yspeed
);

  localparam int XF_W  = X_W + FRAC_W;
  localparam int YF_W  = Y_W + FRAC_W;
  localparam int CNT_W = (ANIM_DIV > 2) ? $clog2(ANIM_DIV) : 1;

  localparam logic [XF_W-1:0]         X_RST    = XF_W'(X_START * (2 ** FRAC_W));
  localparam logic [YF_W-1:0]         Y_RST    = YF_W'(Y_GROUND * (2 ** FRAC_W));
  localparam logic signed [SPD_W-1:0] V_WALK   = SPD_W'(WALK_V);
  localparam logic signed [SPD_W-1:0] V_JUMP   = SPD_W'(-JUMP_V);
  localparam logic signed [SPD_W-1:0] V_MAXF   = SPD_W'(MAX_FALL);
  localparam logic signed [SPD_W:0]   G_EXT    = (SPD_W+1)'(GRAVITY);
  localparam logic signed [SPD_W:0]   MAXF_EXT = (SPD_W+1)'(MAX_FALL);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(ANIM_DIV - 1);

  state_e                  state_q, state_d;
  logic [XF_W-1:0]         x_q, x_d, x_nxt;
  logic [YF_W-1:0]         y_q, y_d, y_nxt;
  logic signed [SPD_W-1:0] xspeed_q, xspeed_d, yspeed_q, yspeed_d;
  logic signed [SPD_W-1:0] xspd_cmd, xspd_fin, ys_grav;
  logic signed [SPD_W:0]   ys_sum;
  logic [3:0]              anim_q, anim_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              run_base;
  logic                    x_lo, x_hi, y_lo, y_hi;
  logic                    grounded, airborne, active, crouch_req;
  logic                    k_right, k_left, k_jump, k_down, key_up_unused;
`ifdef MARIO_DOUBLE_JUMP_EN
  logic                    jprev_q, jprev_d, used_q, used_d;
`endif

  assign k_right       = keydown[KEY_RIGHT];
  assign k_left        = keydown[KEY_LEFT];
  assign k_jump        = keydown[KEY_JUMP];
  assign k_down        = keydown[KEY_DOWN];
  assign key_up_unused = keydown[KEY_UP];

  mario_axis_integrator #(
    .INT_W(X_W), .FRAC_W(FRAC_W), .SPD_W(SPD_W), .MAX_INT(X_MAX)
  ) u_x_axis (
    .pos_i(x_q), .speed_i(xspd_cmd), .pos_o(x_nxt), .at_lo_o(x_lo), .at_hi_o(x_hi)
  );

  mario_axis_integrator #(
    .INT_W(Y_W), .FRAC_W(FRAC_W), .SPD_W(SPD_W), .MAX_INT(Y_GROUND)
  ) u_y_axis (
    .pos_i(y_q), .speed_i(yspeed_q), .pos_o(y_nxt), .at_lo_o(y_lo), .at_hi_o(y_hi)
  );

  always_comb begin
    grounded   = state_q inside {ST_STAND, ST_RUN, ST_CROUCH};
    airborne   = (state_q == ST_AIR);
    active     = grounded || airborne;
    // Crouching is decided from keys alone so it can zero the walk command.
    crouch_req = grounded && k_down && !k_jump;
    xspd_cmd   = '0;
    if (k_right != k_left && !crouch_req) xspd_cmd = k_right ? V_WALK : -V_WALK;
    xspd_fin   = (x_lo || x_hi) ? '0 : xspd_cmd;
    ys_sum     = {yspeed_q[SPD_W-1], yspeed_q} + G_EXT;
    ys_grav    = (ys_sum > MAXF_EXT) ? V_MAXF : ys_sum[SPD_W-1:0];
    run_base   = (state_q == ST_RUN) ? anim_q[1:0] : 2'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_STAND;
      ST_OVER: if (!over && start) state_d = ST_STAND;
      ST_STAND, ST_RUN, ST_CROUCH: begin
        if (over) state_d = ST_OVER;
        else if (tick) begin
          if (k_jump)              state_d = ST_AIR;
          else if (k_down)         state_d = ST_CROUCH;
          else if (xspd_fin != '0) state_d = ST_RUN;
          else                     state_d = ST_STAND;
        end
      end
      ST_AIR: begin
        if (over) state_d = ST_OVER;
        else if (tick && y_hi) state_d = (xspd_fin != '0) ? ST_RUN : ST_STAND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    xspeed_d = xspeed_q;
    yspeed_d = yspeed_q;
    anim_d   = anim_q;
    cnt_d    = cnt_q;
`ifdef MARIO_DOUBLE_JUMP_EN
    jprev_d  = jprev_q;
    used_d   = used_q;
`endif
    if (!active) begin
      xspeed_d = '0;
      yspeed_d = '0;
      cnt_d    = '0;
      anim_d   = (state_q == ST_OVER) ? ANIM_OVER : ANIM_STAND;
      if (state_d == ST_STAND) begin
        x_d    = X_RST;
        y_d    = Y_RST;
        anim_d = ANIM_STAND;
`ifdef MARIO_DOUBLE_JUMP_EN
        jprev_d = 1'b0;
        used_d  = 1'b0;
`endif
      end
    end else if (over) begin
      xspeed_d = '0;
      yspeed_d = '0;
      cnt_d    = '0;
      anim_d   = ANIM_OVER;
    end else if (tick) begin
      x_d      = x_nxt;
      xspeed_d = xspd_fin;
`ifdef MARIO_DOUBLE_JUMP_EN
      jprev_d  = k_jump;
`endif
      if (airborne) begin
        y_d      = y_nxt;
        yspeed_d = ys_grav;
`ifdef MARIO_DOUBLE_JUMP_EN
        if (k_jump && !jprev_q && !used_q) begin
          yspeed_d = V_JUMP;
          used_d   = 1'b1;
        end
`endif
        if (y_hi) begin
          yspeed_d = '0;
`ifdef MARIO_DOUBLE_JUMP_EN
          used_d   = 1'b0;
`endif
        end else if (y_lo) begin
          yspeed_d = '0;
        end
      end else if (state_d == ST_AIR) begin
        yspeed_d = V_JUMP;
      end
      cnt_d = '0;
      case (state_d)
        ST_RUN: begin
          if (cnt_q == CNT_LAST) begin
            anim_d = {2'b00, run_base + 2'd1};
          end else begin
            cnt_d  = cnt_q + 1'b1;
            anim_d = {2'b00, run_base};
          end
        end
        ST_AIR: begin
          anim_d = ANIM_AIR;
`ifdef MARIO_DOUBLE_JUMP_EN
          if (used_d && yspeed_d < 0) anim_d = ANIM_DJUMP;
`endif
        end
        ST_CROUCH: anim_d = ANIM_CROUCH;
        default:   anim_d = ANIM_STAND;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q      <= X_RST;
      y_q      <= Y_RST;
      xspeed_q <= '0;
      yspeed_q <= '0;
      anim_q   <= ANIM_STAND;
      cnt_q    <= '0;
`ifdef MARIO_DOUBLE_JUMP_EN
      jprev_q  <= 1'b0;
      used_q   <= 1'b0;
`endif
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      xspeed_q <= xspeed_d;
      yspeed_q <= yspeed_d;
      anim_q   <= anim_d;
      cnt_q    <= cnt_d;
`ifdef MARIO_DOUBLE_JUMP_EN
      jprev_q  <= jprev_d;
      used_q   <= used_d;
`endif
    end
  end

  assign x               = x_q[XF_W-1:FRAC_W];
  assign y               = y_q[YF_W-1:FRAC_W];
  assign state           = state_q;
  assign animation_state = anim_q;
  assign xspeed          = xspeed_q;
  assign yspeed          = yspeed_q;

endmodule

// File: tb/tb_mario_motion.sv
// Directed-vector bench for mario_motion with hand-computed expectations;
// the MARIO_DOUBLE_JUMP_EN section runs only when that macro is defined.
module tb_mario_motion;

  logic              clk = 1'b0;
  logic              rst, tick, start, over;
  logic [4:0]        keydown;
  logic [9:0]        x;
  logic [8:0]        y;
  logic [2:0]        state;
  logic [3:0]        animation_state;
  logic signed [7:0] xspeed, yspeed;

  int n_vec = 0;
  int n_bad = 0;

  mario_motion dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .over(over),
    .keydown(keydown), .x(x), .y(y), .state(state),
    .animation_state(animation_state), .xspeed(xspeed), .yspeed(yspeed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the next one.
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  task automatic pulse_ctrl(input logic s, input logic o);
    @(negedge clk); start = s; over = o;
    @(negedge clk); start = 1'b0; over = 1'b0;
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; start = 1'b0; over = 1'b0; keydown = 5'b0;
    #12;
    check("rst_x", int'(x), 16);
    check("rst_y", int'(y), 400);
    check("rst_state", int'(state), 0);
    check("rst_anim", int'(animation_state), 0);
    check("rst_xspeed", int'(xspeed), 0);
    check("rst_yspeed", int'(yspeed), 0);
    @(negedge clk); rst = 1'b1;

    // IDLE ignores keys and ticks.
    keydown = 5'b10000;
    do_ticks(2);
    check("idle_x", int'(x), 16);
    check("idle_state", int'(state), 0);

    // Start, then run right.
    pulse_ctrl(1'b1, 1'b0);
    check("start_state", int'(state), 1);
    do_ticks(1);
    check("run_state", int'(state), 2);
    check("run_xspeed", int'(xspeed), 32);
    check("run_x1", int'(x), 18);
    do_ticks(4);
    check("run_anim5", int'(animation_state), 0);
    do_ticks(1);
    check("run_anim6", int'(animation_state), 1);
    do_ticks(4);
    check("run_x10", int'(x), 36);

    // over beats start; OVER freezes everything.
    pulse_ctrl(1'b1, 1'b1);
    check("over_state", int'(state), 5);
    check("over_anim", int'(animation_state), 10);
    check("over_xspeed", int'(xspeed), 0);
    do_ticks(2);
    check("over_frozen_x", int'(x), 36);
    pulse_ctrl(1'b1, 1'b0);
    check("restart_state", int'(state), 1);
    check("restart_x", int'(x), 16);
    check("restart_y", int'(y), 400);

    // Single jump pulse: launch, rise, apex, fall, land.
    keydown = 5'b00100;
    do_ticks(1);
    check("jump_state", int'(state), 3);
    check("jump_yspeed", int'(yspeed), -96);
    check("jump_y0", int'(y), 400);
    check("jump_anim", int'(animation_state), 8);
    keydown = 5'b00000;
    do_ticks(1);
    check("air1_y", int'(y), 394);
    check("air1_yspeed", int'(yspeed), -90);
    do_ticks(15);
    check("apex_y", int'(y), 349);
    check("apex_yspeed", int'(yspeed), 0);
`ifndef MARIO_DOUBLE_JUMP_EN
    keydown = 5'b00100;
`endif
    do_ticks(1);
    keydown = 5'b00000;
    check("air17_yspeed", int'(yspeed), 6);
    check("air17_y", int'(y), 349);
    do_ticks(15);
    check("air32_y", int'(y), 394);
    check("air32_state", int'(state), 3);
    do_ticks(1);
    check("land_state", int'(state), 1);
    check("land_y", int'(y), 400);
    check("land_yspeed", int'(yspeed), 0);
    check("land_anim", int'(animation_state), 0);

    // Hold left into the lower x bound.
    keydown = 5'b01000;
    do_ticks(20);
    check("left_sat_x", int'(x), 0);
    check("left_sat_xspeed", int'(xspeed), 0);

    // Crouch, then jump out of the crouch.
    keydown = 5'b10001;
    do_ticks(1);
    check("crouch_state", int'(state), 4);
    check("crouch_xspeed", int'(xspeed), 0);
    check("crouch_anim", int'(animation_state), 9);
    keydown = 5'b00101;
    do_ticks(1);
    check("crouch_jump_state", int'(state), 3);
    check("crouch_jump_yspeed", int'(yspeed), -96);
    keydown = 5'b00000;
    do_ticks(1);
    check("pre_rst_y", int'(y), 394);

    // Asynchronous reset between edges, mid-jump.
    #2 rst = 1'b0;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_y", int'(y), 400);
    check("arst_x", int'(x), 16);
    check("arst_yspeed", int'(yspeed), 0);
    check("arst_anim", int'(animation_state), 0);
    @(negedge clk); rst = 1'b1;
    pulse_ctrl(1'b1, 1'b0);

`ifdef MARIO_DOUBLE_JUMP_EN
    keydown = 5'b00100;
    do_ticks(1);
    keydown = 5'b00000;
    do_ticks(3);
    check("dj_pre_yspeed", int'(yspeed), -78);
    keydown = 5'b00100;
    do_ticks(1);
    check("dj_yspeed", int'(yspeed), -96);
    check("dj_anim", int'(animation_state), 11);
    keydown = 5'b00000;
    do_ticks(1);
    keydown = 5'b00100;
    do_ticks(1);
    keydown = 5'b00000;
    check("dj_third_yspeed", int'(yspeed), -84);
    check("dj_third_anim", int'(animation_state), 11);
`endif

    pulse_ctrl(1'b0, 1'b1);
    check("over2_state", int'(state), 5);
    pulse_ctrl(1'b1, 1'b0);

    // Hold right into the upper x bound.
    keydown = 5'b10000;
    do_ticks(310);
    check("right_sat_x", int'(x), 624);
    check("right_sat_xspeed", int'(xspeed), 0);
    keydown = 5'b00000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
